processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor_pkg.sv | 85 ++++++++
 rtl/processor_registers.sv | 33 +++
 rtl/processor.sv | 213 +++++++++++++++++++++
 tb/tb_processor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared constants and types for the single-cycle MIPS32 core:
// register numbers, opcode/funct encodings, ALU operations and the
// decoded control word.
package processor_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_T0   = 5'd8;
   localparam logic [4:0] REG_T1   = 5'd9;
   localparam logic [4:0] REG_T2   = 5'd10;
   localparam logic [4:0] REG_T3   = 5'd11;
   localparam logic [4:0] REG_T4   = 5'd12;
   localparam logic [4:0] REG_T5   = 5'd13;
   localparam logic [4:0] REG_T6   = 5'd14;
   localparam logic [4:0] REG_T7   = 5'd15;
   localparam logic [4:0] REG_S0   = 5'd16;
   localparam logic [4:0] REG_S1   = 5'd17;
   localparam logic [4:0] REG_S2   = 5'd18;
   localparam logic [4:0] REG_S3   = 5'd19;
   localparam logic [4:0] REG_S4   = 5'd20;
   localparam logic [4:0] REG_S5   = 5'd21;
   localparam logic [4:0] REG_S6   = 5'd22;
   localparam logic [4:0] REG_S7   = 5'd23;
   localparam logic [4:0] REG_RA   = 5'd31;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_LUI
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    use_imm;
      logic    zero_ext;
      logic    reg_we;
      logic    write_rt;
      logic    mem_we;
      logic    mem_to_reg;
      logic    branch_eq;
      logic    branch_ne;
      logic    jump;
      logic    jump_reg;
      logic    link;
   } ctrl_t;

endpackage

// File: rtl/processor_registers.sv
// 32 x 32-bit register file: two combinational read ports, one write
// port committed on the rising clock edge, $0 hard-wired to zero.
module processor_registers
   import processor_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  read_a,
   input  logic [4:0]  read_b,
   input  logic [4:0]  write_addr,
   input  logic        write_en,
   input  logic [31:0] write_data,
   output logic [31:0] data_a,
   output logic [31:0] data_b
);

   logic [31:0] registers [0:31];

   // Clear every register while reset is low; otherwise commit the write port, dropping writes to $0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            registers[i] <= '0;
         end
      end else if (write_en && (write_addr != REG_ZERO)) begin
         registers[write_addr] <= write_data;
      end
   end

   assign data_a = (read_a == REG_ZERO) ? '0 : registers[read_a];
   assign data_b = (read_b == REG_ZERO) ? '0 : registers[read_b];

endmodule

// File: rtl/processor.sv
// Single-cycle MIPS32 core: fetch, decode, execute, memory and write-back
// all complete within one clock period. Instruction memory is a byte
// array loaded hierarchically; data memory is a big-endian byte array.
module processor
   import processor_pkg::*;
#(
   parameter int IMEM_BYTES = 1024,
   parameter int DMEM_BYTES = 1024
) (
   input logic clk,
   input logic rst_n
);

   localparam int IW = $clog2(IMEM_BYTES);
   localparam int DW = $clog2(DMEM_BYTES);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc_raw;
   logic [31:0] next_pc;
   logic [31:0] instr;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [25:0] target;

   ctrl_t       ctrl;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] imm_ext;
   logic [31:0] src_b;
   logic [31:0] alu_result;
   logic [31:0] load_data;
   logic [31:0] write_data;
   logic [4:0]  write_addr;
   logic        take_branch;

   logic [7:0]    dmem_bytes [0:DMEM_BYTES-1];
   logic [DW-1:0] d0;
   logic          unused_addr_bits;

   // Program counter; the next edge after reset release retires address 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else begin
         pc <= next_pc;
      end
   end

   if (1) begin : IFU
      if (1) begin : imemory
         if (1) begin : storage
            logic [7:0]    bytes [0:IMEM_BYTES-1];
            logic [IW-1:0] i0;

            // Big-endian word fetch at PC, byte addresses wrapping within the memory
            always_comb begin
               i0    = pc[IW-1:0];
               instr = {bytes[i0], bytes[i0 + IW'(1)],
                        bytes[i0 + IW'(2)], bytes[i0 + IW'(3)]};
            end
         end
      end
   end

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   // Decode opcode/funct into a control word; unknown encodings stay all-zero (a no-op)
   always_comb begin : control
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_we = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
               FN_AND:          ctrl.alu_op = ALU_AND;
               FN_OR:           ctrl.alu_op = ALU_OR;
               FN_XOR:          ctrl.alu_op = ALU_XOR;
               FN_NOR:          ctrl.alu_op = ALU_NOR;
               FN_SLT:          ctrl.alu_op = ALU_SLT;
               FN_SLTU:         ctrl.alu_op = ALU_SLTU;
               FN_SLL:          ctrl.alu_op = ALU_SLL;
               FN_SRL:          ctrl.alu_op = ALU_SRL;
               FN_SRA:          ctrl.alu_op = ALU_SRA;
               FN_JR: begin
                  ctrl.reg_we   = 1'b0;
                  ctrl.jump_reg = 1'b1;
               end
               default:         ctrl.reg_we = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
         end
         OP_SLTI: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
            ctrl.alu_op = ALU_SLT;
         end
         OP_ANDI: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
            ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_AND;
         end
         OP_ORI: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
            ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_OR;
         end
         OP_XORI: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
            ctrl.zero_ext = 1'b1; ctrl.alu_op = ALU_XOR;
         end
         OP_LUI: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.alu_op = ALU_LUI;
         end
         OP_LW: begin
            ctrl.reg_we = 1'b1; ctrl.write_rt = 1'b1; ctrl.use_imm = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.use_imm = 1'b1; ctrl.mem_we = 1'b1;
         end
         OP_BEQ:  ctrl.branch_eq = 1'b1;
         OP_BNE:  ctrl.branch_ne = 1'b1;
         OP_J:    ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump = 1'b1; ctrl.link = 1'b1; ctrl.reg_we = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   assign imm_ext    = ctrl.zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   assign src_b      = ctrl.use_imm ? imm_ext : rd2;
   assign write_addr = ctrl.link ? REG_RA : (ctrl.write_rt ? rt : rd);
   assign write_data = ctrl.mem_to_reg ? load_data : (ctrl.link ? pc_plus4 : alu_result);

   processor_registers registers (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_a     (rs),
      .read_b     (rt),
      .write_addr (write_addr),
      .write_en   (ctrl.reg_we),
      .write_data (write_data),
      .data_a     (rd1),
      .data_b     (rd2)
   );

   // Arithmetic/logic/shift datapath; shifts always operate on rt by shamt
   always_comb begin : alu
      alu_result = '0;
      case (ctrl.alu_op)
         ALU_ADD:  alu_result = rd1 + src_b;
         ALU_SUB:  alu_result = rd1 - src_b;
         ALU_AND:  alu_result = rd1 & src_b;
         ALU_OR:   alu_result = rd1 | src_b;
         ALU_XOR:  alu_result = rd1 ^ src_b;
         ALU_NOR:  alu_result = ~(rd1 | src_b);
         ALU_SLT:  alu_result = {31'b0, $signed(rd1) < $signed(src_b)};
         ALU_SLTU: alu_result = {31'b0, rd1 < src_b};
         ALU_SLL:  alu_result = rd2 << shamt;
         ALU_SRL:  alu_result = rd2 >> shamt;
         ALU_SRA:  alu_result = $signed(rd2) >>> shamt;
         ALU_LUI:  alu_result = {imm, 16'h0000};
         default:  alu_result = '0;
      endcase
   end

   // Next-PC selection: branch, jump, jump-register or fall-through, wrapped to the instruction memory
   always_comb begin
      pc_plus4    = pc + 32'd4;
      take_branch = (ctrl.branch_eq && (rd1 == rd2)) || (ctrl.branch_ne && (rd1 != rd2));
      next_pc_raw = pc_plus4;
      if (ctrl.jump_reg) begin
         next_pc_raw = rd1;
      end else if (ctrl.jump) begin
         next_pc_raw = {pc_plus4[31:28], target, 2'b00};
      end else if (take_branch) begin
         next_pc_raw = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
      next_pc = next_pc_raw & 32'(IMEM_BYTES - 1);
   end

   assign d0               = {alu_result[DW-1:2], 2'b00};
   assign load_data        = {dmem_bytes[d0], dmem_bytes[d0 + DW'(1)],
                              dmem_bytes[d0 + DW'(2)], dmem_bytes[d0 + DW'(3)]};
   assign unused_addr_bits = &{1'b0, alu_result[31:DW], alu_result[1:0]};

   // Big-endian word store; held off while reset is asserted so an interrupted store is discarded
   always_ff @(posedge clk) begin : dmemory
      if (rst_n && ctrl.mem_we) begin
         dmem_bytes[d0]           <= rd2[31:24];
         dmem_bytes[d0 + DW'(1)]  <= rd2[23:16];
         dmem_bytes[d0 + DW'(2)]  <= rd2[15:8];
         dmem_bytes[d0 + DW'(3)]  <= rd2[7:0];
      end
   end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for the single-cycle MIPS32 core. Each program is
// loaded into instruction memory, expected register values are queued,
// and after the required number of edges the queue is drained against
// the register file.
module tb_processor;
   import processor_pkg::*;

   typedef struct {
      string       tag;
      int          idx;
      logic [31:0] value;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int          asserts;
   int          failures;
   logic [31:0] prog [$];
   exp_t        sb [$];

   processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rType(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sh, logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] iType(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jType(logic [5:0] op, logic [25:0] addr);
      return {op, addr};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      asserts++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic expectReg(input string tag, input int idx, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.idx   = idx;
      e.value = value;
      sb.push_back(e);
   endtask

   // Hold reset, load the queued program, release and run for a fixed number of edges, then drain the scoreboard
   task automatic applyStimulus(input int edges);
      exp_t e;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 1024; i++) begin
         dut.IFU.imemory.storage.bytes[i] = 8'h00;
      end
      for (int i = 0; i < prog.size(); i++) begin
         dut.IFU.imemory.storage.bytes[4*i]   = prog[i][31:24];
         dut.IFU.imemory.storage.bytes[4*i+1] = prog[i][23:16];
         dut.IFU.imemory.storage.bytes[4*i+2] = prog[i][15:8];
         dut.IFU.imemory.storage.bytes[4*i+3] = prog[i][7:0];
      end
      prog.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (edges) @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput(e.tag, dut.registers.registers[e.idx], e.value);
      end
   endtask

   initial begin
      asserts  = 0;
      failures = 0;
      rst_n    = 1'b0;
      #12;
      checkOutput("reset_pc", dut.pc, 32'h0);
      checkOutput("reset_t0", dut.registers.registers[REG_T0], 32'h0);

      // srl with zero fill
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S0, 16'h0002));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S1, 16'h0010));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S2, 16'h0030));
      prog.push_back(rType(REG_ZERO, REG_S0, REG_T0, 5'd1, FN_SRL));
      prog.push_back(rType(REG_ZERO, REG_S0, REG_T1, 5'd2, FN_SRL));
      prog.push_back(rType(REG_ZERO, REG_S1, REG_T2, 5'd2, FN_SRL));
      prog.push_back(rType(REG_ZERO, REG_S2, REG_T3, 5'd3, FN_SRL));
      expectReg("srl_s0", REG_S0, 32'h2);
      expectReg("srl_s1", REG_S1, 32'h10);
      expectReg("srl_s2", REG_S2, 32'h30);
      expectReg("srl_t0", REG_T0, 32'h1);
      expectReg("srl_t1", REG_T1, 32'h0);
      expectReg("srl_t2", REG_T2, 32'h4);
      expectReg("srl_t3", REG_T3, 32'h6);
      applyStimulus(7);

      // sra sign fill and sll
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S0, 16'hFFF0));
      prog.push_back(rType(REG_ZERO, REG_S0, REG_T0, 5'd2, FN_SRA));
      prog.push_back(rType(REG_ZERO, REG_S0, REG_T1, 5'd1, FN_SLL));
      expectReg("sra_s0", REG_S0, 32'hFFFFFFF0);
      expectReg("sra_t0", REG_T0, 32'hFFFFFFFC);
      expectReg("sll_t1", REG_T1, 32'hFFFFFFE0);
      applyStimulus(3);

      // Store/load round trip plus big-endian byte placement
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S0, 16'h1234));
      prog.push_back(iType(OP_SW,   REG_ZERO, REG_S0, 16'h0008));
      prog.push_back(iType(OP_LW,   REG_ZERO, REG_T0, 16'h0008));
      expectReg("lw_t0", REG_T0, 32'h1234);
      applyStimulus(3);
      checkOutput("dmem_byte8",  {24'h0, dut.dmem_bytes[8]},  32'h00);
      checkOutput("dmem_byte10", {24'h0, dut.dmem_bytes[10]}, 32'h12);
      checkOutput("dmem_byte11", {24'h0, dut.dmem_bytes[11]}, 32'h34);

      // Branches: beq taken, bne not taken, bne taken
      prog.push_back(iType(OP_BEQ,  REG_ZERO, REG_ZERO, 16'h0001));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T0,   16'h0005));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T1,   16'h0003));
      prog.push_back(iType(OP_BNE,  REG_ZERO, REG_ZERO, 16'h0001));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T2,   16'h0009));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T3,   16'h0001));
      prog.push_back(iType(OP_BNE,  REG_T3,   REG_ZERO, 16'h0001));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T4,   16'h0007));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T5,   16'h0002));
      expectReg("beq_skip_t0",  REG_T0, 32'h0);
      expectReg("beq_land_t1",  REG_T1, 32'h3);
      expectReg("bne_fall_t2",  REG_T2, 32'h9);
      expectReg("bne_skip_t4",  REG_T4, 32'h0);
      expectReg("bne_land_t5",  REG_T5, 32'h2);
      applyStimulus(7);

      // Jumps, jal link, lui and jr
      prog.push_back(jType(OP_J, 26'd3));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T0, 16'h0001));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T1, 16'h0002));
      prog.push_back(jType(OP_JAL, 26'd6));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T2, 16'h0003));
      prog.push_back(jType(OP_J, 26'd8));
      prog.push_back(iType(OP_LUI, REG_ZERO, REG_T3, 16'h1234));
      prog.push_back(rType(REG_RA, REG_ZERO, REG_ZERO, 5'd0, FN_JR));
      prog.push_back(iType(OP_ORI, REG_T3, REG_T4, 16'h5678));
      expectReg("j_skip_t0", REG_T0, 32'h0);
      expectReg("j_skip_t1", REG_T1, 32'h0);
      expectReg("jr_ret_t2", REG_T2, 32'h3);
      expectReg("lui_t3",    REG_T3, 32'h12340000);
      expectReg("ori_t4",    REG_T4, 32'h12345678);
      expectReg("jal_ra",    REG_RA, 32'h10);
      applyStimulus(7);

      // ALU mix: signed/unsigned compares, nor, zero-extended logic immediates
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S0, 16'h0005));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S1, 16'hFFFD));
      prog.push_back(rType(REG_S0, REG_S1, REG_T0, 5'd0, FN_SUB));
      prog.push_back(rType(REG_S1, REG_S0, REG_T1, 5'd0, FN_SLT));
      prog.push_back(rType(REG_S1, REG_S0, REG_T2, 5'd0, FN_SLTU));
      prog.push_back(rType(REG_S0, REG_ZERO, REG_T3, 5'd0, FN_NOR));
      prog.push_back(iType(OP_ANDI, REG_S1, REG_T4, 16'hFFFF));
      prog.push_back(iType(OP_XORI, REG_S0, REG_T5, 16'h000F));
      prog.push_back(iType(OP_SLTI, REG_S1, REG_T6, 16'h0000));
      prog.push_back(rType(REG_S0, REG_S1, REG_T7, 5'd0, FN_ADDU));
      expectReg("sub_t0",  REG_T0, 32'h8);
      expectReg("slt_t1",  REG_T1, 32'h1);
      expectReg("sltu_t2", REG_T2, 32'h0);
      expectReg("nor_t3",  REG_T3, 32'hFFFFFFFA);
      expectReg("andi_t4", REG_T4, 32'h0000FFFD);
      expectReg("xori_t5", REG_T5, 32'h0000000A);
      expectReg("slti_t6", REG_T6, 32'h1);
      expectReg("addu_t7", REG_T7, 32'h2);
      applyStimulus(10);

      // $0 stays zero, then asynchronous reset mid-run and restart from 0
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_ZERO, 16'h0007));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_T0,   16'h0005));
      prog.push_back(iType(OP_ADDI, REG_ZERO, REG_S0,   16'h0009));
      expectReg("zero_reg", REG_ZERO, 32'h0);
      expectReg("zero_t0",  REG_T0,   32'h5);
      expectReg("zero_s0",  REG_S0,   32'h9);
      applyStimulus(3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_pc", dut.pc, 32'h0);
      for (int i = 0; i < 32; i++) begin
         checkOutput($sformatf("async_r%0d", i), dut.registers.registers[i], 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("restart_pc", dut.pc, 32'h4);
      checkOutput("restart_t0_pending", dut.registers.registers[REG_T0], 32'h0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("restart_t0", dut.registers.registers[REG_T0], 32'h5);
      checkOutput("dmem_kept", {24'h0, dut.dmem_bytes[11]}, 32'h34);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
